// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Function : Byte-stream UART transmitter. Bytes arriving on a valid/ready
//            handshake are buffered in a small circular FIFO and sent as
//            8N1 frames, LSB first. Define UART_TX_PARITY_EN to insert an
//            even-parity bit between the last data bit and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int c_DIV   = CLK_FREQ / BAUD;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_COUNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_COUNT_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [7:0]         r_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;
    logic [7:0]         w_head;

    assign w_full      = (r_count == c_COUNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = tx_valid && !w_full;
    assign w_baud_done = (r_baud_cnt == c_DIV_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    // The head leaves the FIFO either from IDLE or at the end of a stop bit,
    // so consecutive frames run back-to-back with no idle gap.
    assign w_pop       = !w_empty &&
                         ((r_state == c_ST_IDLE) ||
                          ((r_state == c_ST_STOP) && w_baud_done));

    assign tx_ready = !w_full;
    assign tx       = r_tx;
    assign busy     = (r_state != c_ST_IDLE) || !w_empty;

    // FIFO storage: written on every accepted byte; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_COUNT_ONE;
                2'b01:   r_count <= r_count - c_COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being framed, captured when it is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // Frame sequencer: drives the line from a register so it never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_head;
                        r_baud_cnt <= '0;
                        r_state    <= c_ST_START;
                        r_tx       <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_ST_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= c_ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= c_ST_STOP;
                        r_tx       <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= c_ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Function : Directed self-checking bench for uart_tx_fifo at DIV=10.
//            A line monitor decodes frames at mid-bit; tests cover reset,
//            abort, single-byte waveform, flood, push/pop overlap, pointer
//            wrap and (with UART_TX_PARITY_EN) the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_CLK_FREQ = 1000000;
    localparam int c_BAUD     = 100000;
    localparam int c_DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_FRAME    = 110;
    localparam int c_STOP_POS = 105;
`else
    localparam int c_FRAME    = 100;
    localparam int c_STOP_POS = 95;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (c_CLK_FREQ),
        .BAUD       (c_BAUD),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Line monitor: decodes frames sampled mid-bit on the falling clock edge.
    int         cyc = 0;
    bit         mon_active = 1'b0;
    int         mon_pos = 0;
    logic [7:0] mon_shift = 8'h00;
    int         mon_bad = 0;
    logic [7:0] byte_q [$];
    int         fall_q [$];
    logic       par_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            mon_pos = mon_pos + 1;
            if (mon_pos == 5 && tx !== 1'b0) mon_bad = mon_bad + 1;
            if (mon_pos >= 15 && mon_pos <= 85 && (mon_pos % 10) == 5)
                mon_shift = {tx, mon_shift[7:1]};
            if (mon_pos == 95) par_q.push_back(tx);
            if (mon_pos == c_STOP_POS) begin
                if (tx !== 1'b1) mon_bad = mon_bad + 1;
                byte_q.push_back(mon_shift);
                mon_active = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        byte_q.delete();
        fall_q.delete();
        par_q.delete();
    endtask

    // One-cycle write; returns 1 ns after the accepting edge.
    task automatic send_one(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (byte_q.size() < n && k < budget) begin
            step();
            k = k + 1;
        end
        check("frames_done", 32'(byte_q.size()), 32'(n));
        repeat (10) step();
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < byte_q.size())
                check(tag, 32'(byte_q[i]), 32'(8'(first + 8'(i))));
        end
        for (int i = 1; i < n; i++) begin
            if (i < fall_q.size())
                check({tag, "_gap"}, 32'(fall_q[i] - fall_q[i-1]), 32'(c_FRAME));
        end
    endtask

    // Expected line level k clocks after the accepting edge of byte 0x44.
    function automatic logic exp_wave44(input int k);
        logic [7:0] b;
        b = 8'h44;
        if (k <= 10) return 1'b0;
        if (k <= 90) return b[(k - 11) / 10];
        if (k <= 100 && c_FRAME == 110) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] data;
        logic       rdy;
        int         acc;
        int         guard;
        int         lows;
        int         extra;
        bit         full_seen;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // ---- abort 35 clocks into a 0xFF frame ----
        send_one(8'hFF);
        repeat (34) step();
        check("abort_ff_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_ff_tx", 32'(tx), 32'd1);
        check("abort_ff_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        check("abort_ff_busy_rel", 32'(busy), 32'd0);
        check("abort_ff_ready_rel", 32'(tx_ready), 32'd1);

        // ---- abort during the start bit: line must rise with no clock edge ----
        send_one(8'h00);
        repeat (4) step();
        check("abort_st_pre", 32'(tx), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_st_tx", 32'(tx), 32'd1);
        step();
        reset = 1'b0;
        clear_q();
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx == 1'b0) lows = lows + 1;
        end
        check("abort_quiet", 32'(lows), 32'd0);
        check("abort_no_frames", 32'(fall_q.size()), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        // ---- single byte 0x44 waveform ----
        clear_q();
        send_one(8'h44);
        check("t44_edge_tx", 32'(tx), 32'd1);
        check("t44_edge_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= c_FRAME; k++) begin
            step();
            check("t44_wave", 32'(tx), 32'(exp_wave44(k)));
        end
        check("t44_busy_last", 32'(busy), 32'd1);
        step();
        check("t44_busy_drop", 32'(busy), 32'd0);
        check("t44_count", 32'(byte_q.size()), 32'd1);
        if (byte_q.size() > 0) check("t44_byte", 32'(byte_q[0]), 32'h44);
`ifdef UART_TX_PARITY_EN
        if (par_q.size() > 0) check("t44_parity", 32'(par_q[0]), 32'd0);
`endif
        repeat (5) step();

        // ---- continuous-valid flood ----
        clear_q();
        data = 8'h41; acc = 0; guard = 0; full_seen = 1'b0;
        tx_valid = 1'b1;
        tx_data  = data;
        while (acc < 6 && guard < 2000) begin
            rdy = tx_ready;
            if (!rdy && !full_seen) begin
                full_seen = 1'b1;
                check("flood_full_after", 32'(acc), 32'(c_DEPTH + 1));
            end
            step();
            guard = guard + 1;
            if (rdy) begin
                acc  = acc + 1;
                data = data + 8'd1;
                tx_data = data;
            end
        end
        tx_valid = 1'b0;
        check("flood_full_seen", 32'(full_seen), 32'd1);
        wait_frames(6, 1000);
        check_bytes("flood_byte", 8'h41, 6);

        // ---- push on the same edge the stop bit pops, FIFO at 2 ----
        clear_q();
        tx_valid = 1'b1;
        tx_data = 8'hA0; step();
        tx_data = 8'hA1; step();
        tx_data = 8'hA2; step();
        tx_valid = 1'b0;
        repeat (c_FRAME - 2) step();
        check("pp_stop_level", 32'(tx), 32'd1);
        check("pp_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        step();
        check("pp_aligned", 32'(tx), 32'd0);
        tx_data = 8'hA4;
        extra = 0; guard = 0;
        while (tx_ready && guard < 20) begin
            step();
            extra = extra + 1;
            guard = guard + 1;
            tx_data = 8'(8'hA4 + 8'(extra));
        end
        tx_valid = 1'b0;
        check("pp_room_left", 32'(extra), 32'd2);
        wait_frames(6, 1000);
        check_bytes("pp_byte", 8'hA0, 6);

        // ---- pointer wrap: 9 bytes through depth 4 ----
        clear_q();
        acc = 0; guard = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h30;
        while (acc < 9 && guard < 3000) begin
            rdy = tx_ready;
            step();
            guard = guard + 1;
            if (rdy) begin
                acc = acc + 1;
                tx_data = 8'(8'h30 + 8'(acc));
            end
        end
        tx_valid = 1'b0;
        check("wrap_sent", 32'(acc), 32'd9);
        wait_frames(9, 1200);
        check_bytes("wrap_byte", 8'h30, 9);

`ifdef UART_TX_PARITY_EN
        // ---- odd number of ones gives parity bit 1 ----
        clear_q();
        send_one(8'h07);
        wait_frames(1, 200);
        if (byte_q.size() > 0) check("par07_byte", 32'(byte_q[0]), 32'h07);
        check("par07_count", 32'(par_q.size()), 32'd1);
        if (par_q.size() > 0) check("par07_parity", 32'(par_q[0]), 32'd1);
`endif

        check("mon_frame_errors", 32'(mon_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
